// File: rtl/dac_player_pkg.sv
// Shared types and defaults for the DAC playback path.
package dac_player_pkg;

  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_SPD_W    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    READY = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Frame-level advance decision, taken on the left-slot edge.
  typedef enum logic [1:0] {
    ADV_NONE = 2'd0,
    ADV_STEP = 2'd1,
    ADV_END  = 2'd2
  } adv_e;

  localparam logic [1:0] LRC_FALL = 2'b10;
  localparam logic [1:0] LRC_RISE = 2'b01;

endpackage

// File: rtl/dac_player_if.sv
// Playback control bundle: transport controls in, done status out.
interface dac_player_if
  import dac_player_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SPD_W  = DEF_SPD_W
);
  logic              play;
  logic              restart;
  logic              slow;
  logic [SPD_W-1:0]  speed;
  logic [ADDR_W-1:0] stop_addr;
  logic              done;

  modport master (output play, restart, slow, speed, stop_addr, input done);
  modport slave  (input play, restart, slow, speed, stop_addr, output done);
endinterface

// File: rtl/dac_player_shifter.sv
// MSB-first serialiser for one codec slot; idles low between slots.
module dac_player_shifter
  import dac_player_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] data,
  output logic                dacdat,
  output logic                busy,
  output logic                last
);
  localparam int CNT_W = $clog2(SAMPLE_W);

  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d;
  logic                dacdat_q, dacdat_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    dacdat_d  = dacdat_q;
    if (abort) begin
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      dacdat_d  = 1'b0;
    end else if (load) begin
      shreg_d   = data;
      bit_cnt_d = CNT_W'(SAMPLE_W - 1);
      busy_d    = 1'b1;
      dacdat_d  = data[SAMPLE_W-1];
    end else if (busy_q) begin
      // Final bit has been on the line for a cycle: drop back to silence.
      if (bit_cnt_q == '0) begin
        busy_d   = 1'b0;
        dacdat_d = 1'b0;
      end else begin
        dacdat_d  = shreg_q[SAMPLE_W-2];
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      dacdat_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      dacdat_q  <= dacdat_d;
    end
  end

  assign dacdat = dacdat_q;
  assign busy   = busy_q;
  assign last   = busy_q && (bit_cnt_q == '0);

endmodule

// File: rtl/dac_player.sv
// Playback controller: fetches recorded samples from SRAM and streams each one
// to both codec slots, with fast-forward / slow-motion address sequencing.
module dac_player
  import dac_player_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SPD_W    = DEF_SPD_W
) (
  input  logic                bclk,
  input  logic                reset,
  input  logic                daclrc,
  dac_player_if.slave         ctl,
  input  logic [SAMPLE_W-1:0] sram_dq,
  output logic [ADDR_W-1:0]   addr,
  output logic                sram_oe,
  output logic                dacdat
);

  state_e              state_q, state_d;
  adv_e                adv_q, adv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
  logic [SPD_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic [SAMPLE_W-1:0] sample_buf_q, sample_buf_d;
  logic                right_q, right_d;
  logic [1:0]          lrc_hist_q;

  logic              fall, rise, load, abort, last, busy;
  logic [SPD_W-1:0]  spd;
  logic [ADDR_W:0]   cand;

  function automatic logic [SPD_W-1:0] eff_speed(input logic [SPD_W-1:0] s);
    return (s == '0) ? {{(SPD_W-1){1'b0}}, 1'b1} : s;
  endfunction

  assign fall = (lrc_hist_q == LRC_FALL);
  assign rise = (lrc_hist_q == LRC_RISE);
  assign spd  = eff_speed(ctl.speed);
  // One extra bit so a step past the top of memory still compares as "beyond stop".
  assign cand = {1'b0, addr_q} + (ctl.slow ? (ADDR_W+1)'(1) : (ADDR_W+1)'(spd));

  always_comb begin
    state_d      = state_q;
    adv_d        = adv_q;
    addr_d       = addr_q;
    nxt_addr_d   = nxt_addr_q;
    rep_cnt_d    = rep_cnt_q;
    sample_buf_d = sample_buf_q;
    right_d      = right_q;
    load         = 1'b0;
    abort        = 1'b0;
    if (ctl.restart) begin
      state_d   = IDLE;
      addr_d    = '0;
      rep_cnt_d = '0;
      adv_d     = ADV_NONE;
      abort     = 1'b1;
    end else if (!ctl.play) begin
      state_d = IDLE;
      adv_d   = ADV_NONE;
      abort   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = WAIT;
        WAIT: begin
          sample_buf_d = sram_dq;
          state_d      = READY;
        end
        READY: begin
          if (fall || rise) begin
            load    = 1'b1;
            right_d = rise;
            state_d = SHIFT;
            if (fall) begin
              if (ctl.slow && (rep_cnt_q != spd - 1'b1)) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
                adv_d     = ADV_NONE;
              end else begin
                rep_cnt_d  = '0;
                nxt_addr_d = cand[ADDR_W-1:0];
                adv_d      = (cand > {1'b0, ctl.stop_addr}) ? ADV_END : ADV_STEP;
              end
            end
          end
        end
        SHIFT: begin
          // The decision from the left slot is applied once the right slot
          // has finished, so both channels carry the same sample.
          if (last || !busy) begin
            if (right_q && adv_q == ADV_STEP) begin
              addr_d  = nxt_addr_q;
              adv_d   = ADV_NONE;
              state_d = FETCH;
            end else if (right_q && adv_q == ADV_END) begin
              adv_d   = ADV_NONE;
              state_d = DONE;
            end else begin
              state_d = READY;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (!reset) begin
      state_q      <= IDLE;
      adv_q        <= ADV_NONE;
      addr_q       <= '0;
      nxt_addr_q   <= '0;
      rep_cnt_q    <= '0;
      sample_buf_q <= '0;
      right_q      <= 1'b0;
      lrc_hist_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      adv_q        <= adv_d;
      addr_q       <= addr_d;
      nxt_addr_q   <= nxt_addr_d;
      rep_cnt_q    <= rep_cnt_d;
      sample_buf_q <= sample_buf_d;
      right_q      <= right_d;
      lrc_hist_q   <= {lrc_hist_q[0], daclrc};
    end
  end

  dac_player_shifter #(.SAMPLE_W(SAMPLE_W)) u_shifter (
    .clk    (bclk),
    .reset  (reset),
    .load   (load),
    .abort  (abort),
    .data   (sample_buf_q),
    .dacdat (dacdat),
    .busy   (busy),
    .last   (last)
  );

  assign addr     = ctl.play ? addr_q : {ADDR_W{1'bz}};
  assign sram_oe  = (state_q == FETCH) && ctl.play;
  assign ctl.done = (state_q == DONE);

endmodule

// File: tb/tb_dac_player.sv
// Bench for dac_player: frame-level playback model compared slot by slot.
module tb_dac_player;
  import dac_player_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int SW = DEF_SAMPLE_W;
  localparam int H  = 20;

  logic          bclk = 1'b0;
  logic          reset = 1'b0;
  logic          daclrc = 1'b1;
  logic [SW-1:0] sram_dq = '0;
  wire  [AW-1:0] addr;
  logic          sram_oe;
  logic          dacdat;

  dac_player_if ctl ();

  dac_player dut (
    .bclk    (bclk),
    .reset   (reset),
    .daclrc  (daclrc),
    .ctl     (ctl),
    .sram_dq (sram_dq),
    .addr    (addr),
    .sram_oe (sram_oe),
    .dacdat  (dacdat)
  );

  always #5 bclk = ~bclk;

  logic [15:0] mem [0:255];
  always @(posedge bclk) if (sram_oe) sram_dq <= mem[addr[7:0]];

  int checks = 0;
  int failures = 0;
  int m_addr, m_rep, cfg_speed, cfg_stop;
  bit m_done, cfg_slow;

  // One codec half-frame: drive daclrc and collect the slot word.
  task automatic half(input logic lvl, output logic [15:0] w, output bit gap_ok);
    daclrc = lvl;
    w = '0;
    gap_ok = 1'b1;
    for (int i = 1; i <= H; i++) begin
      @(posedge bclk); #1;
      if (i >= 2 && i <= 17) w[17-i] = dacdat;
      else if (dacdat !== 1'b0) gap_ok = 1'b0;
    end
  endtask

  task automatic frame(output logic [17:0] a, output logic [15:0] l, output logic [15:0] r,
                       output bit g, output logic d, output logic oe);
    bit g1, g2;
    a = addr;
    half(1'b0, l, g1);
    half(1'b1, r, g2);
    g  = g1 & g2;
    d  = ctl.done;
    oe = sram_oe;
  endtask

  // Reference: one frame plays mem[addr] on both channels, then the address
  // moves by speed (fast) or by one every speed-th frame (slow) until past stop.
  task automatic model_frame(output logic [17:0] ea, output logic [15:0] ev, output logic ed);
    int spd, nxt;
    ea = 18'(m_addr);
    if (m_done) ev = '0;
    else begin
      ev  = mem[m_addr];
      spd = (cfg_speed == 0) ? 1 : cfg_speed;
      nxt = -1;
      if (!cfg_slow) nxt = m_addr + spd;
      else if (m_rep == spd - 1) begin m_rep = 0; nxt = m_addr + 1; end
      else m_rep++;
      if (nxt >= 0) begin
        if (nxt > cfg_stop) m_done = 1'b1;
        else m_addr = nxt;
      end
    end
    ed = m_done;
  endtask

  task automatic step_frame(output logic [52:0] got, output logic [52:0] exp);
    logic [17:0] a, ea;
    logic [15:0] l, r, ev;
    bit g;
    logic d, oe, ed;
    model_frame(ea, ev, ed);
    frame(a, l, r, g, d, oe);
    got = {a, l, r, g, d, oe};
    exp = {ea, ev, ev, 1'b1, ed, 1'b0};
  endtask

  task automatic start_play(input int spd, input bit slw, input int stp);
    cfg_speed = spd; cfg_slow = slw; cfg_stop = stp;
    ctl.speed = 3'(spd); ctl.slow = slw; ctl.stop_addr = 18'(stp);
    ctl.play = 1'b0; ctl.restart = 1'b1;
    @(posedge bclk); #1;
    ctl.restart = 1'b0; ctl.play = 1'b1;
    repeat (4) @(posedge bclk);
    #1;
    m_addr = 0; m_rep = 0; m_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge bclk);
    #1;
    checks++; if (dacdat !== 1'b0) begin failures++; $display("FAIL reset_dacdat got=%b exp=0", dacdat); end
    checks++; if (sram_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", sram_oe); end
    checks++; if (ctl.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", ctl.done); end
    reset = 1'b1;
    repeat (2) @(posedge bclk);
    #1;
    checks++;
    if ({dacdat, sram_oe, ctl.done} !== 3'b000) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=000", {dacdat, sram_oe, ctl.done});
    end
  endtask

  task automatic test_normal;
    logic [52:0] got, exp;
    mem[0] = 16'hA5C3; mem[1] = 16'h0001;
    start_play(1, 1'b0, 100);
    for (int f = 0; f < 3; f++) begin
      step_frame(got, exp); checks++;
      if (got !== exp) begin failures++; $display("FAIL normal_f%0d got=%h exp=%h (addr,l,r,gap,done,oe)", f, got, exp); end
    end
    checks++;
    if (m_addr != 3 || mem[0] !== 16'hA5C3) begin failures++; $display("FAIL normal_model got=%0d exp=3", m_addr); end
  endtask

  task automatic test_fast;
    logic [52:0] got, exp;
    start_play(4, 1'b0, 10);
    for (int f = 0; f < 5; f++) begin
      step_frame(got, exp); checks++;
      if (got !== exp) begin failures++; $display("FAIL fast_f%0d got=%h exp=%h (addr,l,r,gap,done,oe)", f, got, exp); end
    end
    checks++;
    if (ctl.done !== 1'b1 || addr !== 18'd8) begin
      failures++; $display("FAIL fast_done got=%b/%0d exp=1/8", ctl.done, addr);
    end
    start_play(1, 1'b0, 0);
    for (int f = 0; f < 2; f++) begin
      step_frame(got, exp); checks++;
      if (got !== exp) begin failures++; $display("FAIL stop0_f%0d got=%h exp=%h (addr,l,r,gap,done,oe)", f, got, exp); end
    end
  endtask

  task automatic test_slow;
    logic [52:0] got, exp;
    start_play(3, 1'b1, 100);
    for (int f = 0; f < 7; f++) begin
      step_frame(got, exp); checks++;
      if (got !== exp) begin failures++; $display("FAIL slow_f%0d got=%h exp=%h (addr,l,r,gap,done,oe)", f, got, exp); end
    end
  endtask

  task automatic test_pause_restart;
    logic [52:0] got, exp;
    logic [15:0] r;
    bit bad, g;
    start_play(1, 1'b0, 100);
    for (int f = 0; f < 5; f++) begin
      step_frame(got, exp); checks++;
      if (got !== exp) begin failures++; $display("FAIL prepause_f%0d got=%h exp=%h", f, got, exp); end
    end
    checks++; if (addr !== 18'd5) begin failures++; $display("FAIL pause_addr got=%0d exp=5", addr); end
    daclrc = 1'b0;
    repeat (8) @(posedge bclk);
    #1;
    ctl.play = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge bclk); #1; if (dacdat !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL pause_silent got=active exp=0"); end
    daclrc = 1'b1;
    repeat (H) @(posedge bclk);
    #1;
    ctl.play = 1'b1;
    repeat (4) @(posedge bclk);
    #1;
    step_frame(got, exp); checks++;
    if (got !== exp) begin failures++; $display("FAIL resume got=%h exp=%h", got, exp); end
    // restart pulse lands on the same edge the fall is acted on
    daclrc = 1'b0;
    @(posedge bclk); #1;
    ctl.restart = 1'b1;
    @(posedge bclk); #1;
    ctl.restart = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 18; i++) begin @(posedge bclk); #1; if (dacdat !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL restart_silent got=active exp=0"); end
    checks++; if (addr !== 18'd0) begin failures++; $display("FAIL restart_addr got=%0d exp=0", addr); end
    half(1'b1, r, g);
    checks++;
    if ({r, g} !== {mem[0], 1'b1}) begin failures++; $display("FAIL restart_right got=%h/%b exp=%h/1", r, g, mem[0]); end
    m_addr = 0; m_rep = 0; m_done = 1'b0;
    step_frame(got, exp); checks++;
    if (got !== exp) begin failures++; $display("FAIL post_restart got=%h exp=%h", got, exp); end
  endtask

  task automatic test_edge_in_fetch;
    logic [52:0] got, exp;
    logic [15:0] l, r;
    bit g1, g2;
    ctl.play = 1'b0;
    repeat (3) @(posedge bclk);
    #1;
    ctl.play = 1'b1;
    @(posedge bclk); #1;
    half(1'b0, l, g1);
    half(1'b1, r, g2);
    checks++; if ({l, g1} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL fetch_edge_left got=%h/%b exp=0000/1", l, g1); end
    checks++; if ({r, g2} !== {mem[m_addr], 1'b1}) begin failures++; $display("FAIL fetch_edge_right got=%h/%b exp=%h/1", r, g2, mem[m_addr]); end
    checks++; if (addr !== 18'(m_addr)) begin failures++; $display("FAIL fetch_edge_addr got=%0d exp=%0d", addr, m_addr); end
    step_frame(got, exp); checks++;
    if (got !== exp) begin failures++; $display("FAIL fetch_edge_next got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random;
    logic [52:0] got, exp;
    int spd;
    for (int it = 0; it < 6; it++) begin
      spd = (it == 0) ? 0 : int'($urandom_range(0, 7));
      start_play(spd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)));
      for (int f = 0; f < 12; f++) begin
        step_frame(got, exp); checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rand%0d_f%0d spd=%0d slow=%0b stop=%0d got=%h exp=%h", it, f, cfg_speed, cfg_slow, cfg_stop, got, exp);
        end
      end
    end
  endtask

  initial begin
    ctl.play = 1'b0; ctl.restart = 1'b0; ctl.slow = 1'b0;
    ctl.speed = 3'd1; ctl.stop_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(1, 65535));
    test_reset;
    test_normal;
    test_fast;
    test_slow;
    test_pause_restart;
    test_edge_in_fetch;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
